// File: rtl/alu16_sequencer_pkg.sv
// Shared definitions for the two-pass 16-bit ALU sequencer: op codes, FSM states,
// flag bit positions and the per-pass operand-select helpers.
package alu16_sequencer_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned FLAG_W = 4;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        OP_ADD16 = 2'b00,
        OP_INC16 = 2'b01,
        OP_DEC16 = 2'b10,
        OP_ADDSP = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Second ALU operand for the low pass.
    function automatic logic [BYTE_W-1:0] lo_operand_b(input op_e op, input logic [WORD_W-1:0] opb);
        logic [BYTE_W-1:0] b;
        case (op)
            OP_INC16: b = 8'h00;
            OP_DEC16: b = 8'hFF;
            default:  b = opb[BYTE_W-1:0];
        endcase
        return b;
    endfunction

    // Second ALU operand for the high pass; ADDSP sign-extends e8 into the high byte.
    function automatic logic [BYTE_W-1:0] hi_operand_b(input op_e op, input logic [WORD_W-1:0] opb);
        logic [BYTE_W-1:0] b;
        case (op)
            OP_ADD16: b = opb[WORD_W-1:BYTE_W];
            OP_INC16: b = 8'h00;
            OP_DEC16: b = 8'hFF;
            default:  b = {BYTE_W{opb[BYTE_W-1]}};
        endcase
        return b;
    endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Drives an external 8-bit adder through low and high byte passes to run 16-bit
// ADD16/INC16/DEC16/ADDSP, capturing the result and SM83-style flags.
module alu16_sequencer
    import alu16_sequencer_pkg::*;
#(
    parameter bit BACK_TO_BACK = 1'b1,
    parameter bit IDLE_ZERO    = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [15:0]       opa,
    input  logic [15:0]       opb,
    input  logic [3:0]        flags_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic [3:0]        flags_out,
    output logic              flags_we,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_cin,
    input  logic [7:0]        alu_sum,
    input  logic              alu_cout,
    input  logic              alu_hout
);

    state_e              state, state_next;
    op_e                 op_q, op_d;
    logic [WORD_W-1:0]   opa_q, opa_d;
    logic [WORD_W-1:0]   opb_q, opb_d;
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [BYTE_W-1:0]   sum_lo, sum_lo_d;
    logic                c_lo, c_lo_d;
    logic                h_lo, h_lo_d;
    logic [WORD_W-1:0]   result_d;
    logic [FLAG_W-1:0]   flags_out_d;
    logic                busy_d, done_d, flags_we_d;
    logic [BYTE_W-1:0]   alu_a_d, alu_b_d;
    logic                alu_cin_d;
    logic                accept_c;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state, operand select for the upcoming pass, and pass capture
    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        flags_d     = flags_q;
        sum_lo_d    = sum_lo;
        c_lo_d      = c_lo;
        h_lo_d      = h_lo;
        result_d    = result;
        flags_out_d = flags_out;
        done_d      = 1'b0;
        flags_we_d  = 1'b0;
        alu_a_d     = IDLE_ZERO ? '0 : alu_a;
        alu_b_d     = IDLE_ZERO ? '0 : alu_b;
        alu_cin_d   = IDLE_ZERO ? 1'b0 : alu_cin;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept_c   = 1'b1;
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                state_next = ST_HI;
                sum_lo_d   = alu_sum;
                c_lo_d     = alu_cout;
                h_lo_d     = alu_hout;
                alu_a_d    = opa_q[WORD_W-1:BYTE_W];
                alu_b_d    = hi_operand_b(op_q, opb_q);
                alu_cin_d  = alu_cout;
            end
            ST_HI: begin
                state_next = ST_DONE;
                result_d   = {alu_sum, sum_lo};
                done_d     = 1'b1;
                case (op_q)
                    OP_ADD16: begin
                        flags_out_d         = '0;
                        flags_out_d[FLAG_Z] = flags_q[FLAG_Z];
                        flags_out_d[FLAG_H] = alu_hout;
                        flags_out_d[FLAG_C] = alu_cout;
                        flags_we_d          = 1'b1;
                    end
                    OP_ADDSP: begin
                        flags_out_d         = '0;
                        flags_out_d[FLAG_H] = h_lo;
                        flags_out_d[FLAG_C] = c_lo;
                        flags_we_d          = 1'b1;
                    end
                    default: flags_out_d = flags_q;
                endcase
            end
            ST_DONE: begin
                if (BACK_TO_BACK && req) begin
                    accept_c   = 1'b1;
                    state_next = ST_LO;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Accept loads the low-pass operands straight from the request inputs
        if (accept_c) begin
            op_d      = op_e'(op);
            opa_d     = opa;
            opb_d     = opb;
            flags_d   = flags_in;
            alu_a_d   = opa[BYTE_W-1:0];
            alu_b_d   = lo_operand_b(op_e'(op), opb);
            alu_cin_d = (op_e'(op) == OP_INC16);
        end

        busy_d = (state_next != ST_IDLE);
    end

    // Operand latches, pass capture and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q      <= OP_ADD16;
            opa_q     <= '0;
            opb_q     <= '0;
            flags_q   <= '0;
            sum_lo    <= '0;
            c_lo      <= 1'b0;
            h_lo      <= 1'b0;
            result    <= '0;
            flags_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            flags_we  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
        end else begin
            op_q      <= op_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            flags_q   <= flags_d;
            sum_lo    <= sum_lo_d;
            c_lo      <= c_lo_d;
            h_lo      <= h_lo_d;
            result    <= result_d;
            flags_out <= flags_out_d;
            busy      <= busy_d;
            done      <= done_d;
            flags_we  <= flags_we_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_cin   <= alu_cin_d;
        end
    end

endmodule
